// File: rtl/snd_link_tx.sv
// rtl/snd_link_tx.sv - SND-path word FIFO and UART 8N1 serializer (4 bytes per word, LSB first)
module snd_link_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd,
  input  logic [31:0] interface_data,
  output logic        tx,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic [31:0]    shift_q, shift_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           fifo_full_q, fifo_full_d;
  logic           overflow_q, overflow_d;
  logic           tx_q, tx_d;
  logic           tx_busy_q, tx_busy_d;
  logic [31:0]    mem_q [FIFO_DEPTH];
  logic [31:0]    mem_d [FIFO_DEPTH];
  logic           push, pop, baud_end;

  always_comb begin
    // Full is the registered flag, so a same-edge pop never rescues a push into a full FIFO.
    push       = snd && !fifo_full_q;
    pop        = (state_q == IDLE) && (count_q != '0);
    baud_end   = (baud_q == 16'(CLK_DIV - 1));

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = snd && fifo_full_q;
    if (push) begin
      mem_d[wr_ptr_q] = interface_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    fifo_full_d = (count_d == CW'(FIFO_DEPTH));

    state_d    = state_q;
    baud_d     = baud_q + 16'd1;
    bit_d      = bit_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (pop) begin
          shift_d    = mem_q[rd_ptr_q];
          byte_idx_d = '0;
          state_d    = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[31:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_busy_d = (state_q != IDLE) || (count_q != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_full_q <= fifo_full_d;
      overflow_q  <= overflow_d;
      tx_q        <= tx_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  // Storage needs no reset: pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx        = tx_q;
  assign tx_busy   = tx_busy_q;
  assign fifo_full = fifo_full_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_snd_link_tx.sv
// tb/tb_snd_link_tx.sv - scoreboard bench for snd_link_tx with a timing-level line model
module tb_snd_link_tx;
  localparam int     DIV   = 4;
  localparam int     DEPTH = 4;
  localparam longint WORD  = 40 * DIV;

  logic        clk = 1'b0, rst_n = 1'b0, snd = 1'b0;
  logic [31:0] interface_data = '0;
  logic        tx, tx_busy, fifo_full, overflow;

  snd_link_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .snd(snd), .interface_data(interface_data),
    .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Model: each accepted word gets a pop edge = max(push+1, previous pop + 40*DIV + 1);
  // its bytes start on the line one edge after the pop, 10*DIV apart.
  typedef struct {longint push_e; longint pop_e;} ent_t;
  typedef struct {logic [7:0] b; longint st;} byte_t;
  ent_t   pend[$];
  byte_t  exp_b[$];
  longint ovf_e[$];
  longint last_pop = -1000000;
  int     ovf_seen = 0;

  function automatic int occ_after(longint c);
    int n = 0;
    foreach (pend[i]) if (pend[i].push_e <= c && pend[i].pop_e > c) n++;
    return n;
  endfunction

  function automatic bit busy_after(longint c);
    foreach (pend[i]) if (pend[i].push_e <= c - 1 && c - 1 < pend[i].pop_e + WORD) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    pend.delete(); exp_b.delete(); ovf_e.delete();
    last_pop = -1000000;
  endtask

  task automatic send(input logic [31:0] w);
    longint e, p;
    e = cyc + 1;
    while (pend.size() > 0 && pend[0].pop_e + WORD + 2 < e) void'(pend.pop_front());
    snd = 1'b1; interface_data = w;
    if (occ_after(e - 1) == DEPTH) begin
      ovf_e.push_back(e);
    end else begin
      p = (e + 1 > last_pop + WORD + 1) ? e + 1 : last_pop + WORD + 1;
      last_pop = p;
      pend.push_back('{e, p});
      for (int j = 0; j < 4; j++) exp_b.push_back('{w[8*j +: 8], p + 1 + j * 10 * DIV});
    end
    @(posedge clk); #1;
    snd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_b.size() == 0 && !tx_busy) break;
    end
    check("drain_pending_bytes", exp_b.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: per-cycle flag checks plus a UART decoder sampling mid-bit.
  bit         inframe = 1'b0;
  int         t = 0;
  logic [9:0] bits;
  bit         eo;

  always @(negedge clk) begin
    if (!rst_n) begin
      inframe = 1'b0;
    end else begin
      eo = (ovf_e.size() > 0 && ovf_e[0] == cyc);
      if (eo) void'(ovf_e.pop_front());
      check("overflow", overflow, eo);
      if (overflow) ovf_seen++;
      check("fifo_full", fifo_full, occ_after(cyc) == DEPTH);
      check("tx_busy", tx_busy, busy_after(cyc));
      if (!inframe && tx === 1'b0) begin
        inframe = 1'b1; t = 0;
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: tx fell at cycle %0d with no byte pending", cyc);
        end else begin
          check("start_edge", cyc, exp_b[0].st);
        end
      end
      if (inframe) begin
        if (t % DIV == DIV / 2) begin
          bits[t / DIV] = tx;
          if (t / DIV == 9) begin
            check("start_bit", bits[0], 0);
            check("stop_bit", bits[9], 1);
            if (exp_b.size() > 0) begin
              check("byte_value", bits[8:1], exp_b[0].b);
              void'(exp_b.pop_front());
            end
            inframe = 1'b0;
          end
        end
        t++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  longint e0, fall;
  logic [31:0] w;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_full", fifo_full, 0);
    check("reset_ovf", overflow, 0);
    @(posedge clk); #1;
    idle(50);

    // Single word: fall two edges after the push, busy drops 160 cycles after the start edge.
    e0 = cyc + 1;
    send(32'hA53C0F81);
    fall = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin fall = cyc; break; end
    end
    check("first_fall_edge", fall, e0 + 2);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!tx_busy) break;
    end
    check("busy_fall_delay", cyc - fall, 160);
    @(posedge clk); #1;
    drain(100);

    // Five back-to-back strobes: the first pops before the fifth arrives.
    ovf_seen = 0;
    for (int k = 1; k <= 5; k++) send(32'(k));
    drain(1200);
    check("five_no_overflow", ovf_seen, 0);

    // Six back-to-back strobes: the sixth meets a full FIFO.
    ovf_seen = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) check("full_at_sixth", fifo_full, 1);
      send(32'(k));
    end
    drain(1200);
    check("six_one_overflow", ovf_seen, 1);

    // Reset in the middle of the second byte's data bits.
    e0 = cyc + 1;
    send(32'h11223344);
    while (cyc < e0 + 1 + 1 + 10 * DIV + 4 * DIV) @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("post_reset_tx", tx, 1);
    check("post_reset_full", fifo_full, 0);
    check("post_reset_busy", tx_busy, 0);
    @(posedge clk); #1;
    idle(60);
    send(32'h000000FF);
    drain(300);

    // Randomized traffic: bursts overflow, sparse gaps let the FIFO drain.
    ovf_seen = 0;
    for (int k = 0; k < 40; k++) begin
      w = $urandom;
      send(w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(100, 250));
      else if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 20));
    end
    drain(5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
